// File: rtl/lcd_pkg.sv
// Shared HD44780 constants and reader state encoding, usable by both the
// command writer and the status reader.
package lcd_pkg;

   localparam int unsigned T_AS     = 2;
   localparam int unsigned T_EH     = 25;
   localparam int unsigned T_AH     = 2;
   localparam int unsigned T_GAP    = 25;
   localparam int unsigned POLL_MAX = 2000;

   localparam int unsigned TMR_W  = 5;
   localparam int unsigned PCNT_W = 11;

   localparam int unsigned BF_BIT = 7;
   localparam int unsigned AC_MSB = 6;

   localparam logic RS_STATUS = 1'b0;
   localparam logic RW_WRITE  = 1'b0;
   localparam logic RW_READ   = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_EN_HIGH,
      S_HOLD,
      S_CHECK,
      S_GAP,
      S_DONE
   } rd_state_t;

   // Phase timer counts down to zero, so a phase of N cycles loads N-1.
   function automatic logic [TMR_W-1:0] phase_load(input int unsigned cycles);
      return TMR_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/lcd_status_reader_if.sv
// Request/response handshake between a host and the LCD status reader.
interface lcd_status_reader_if;
   import lcd_pkg::*;

   logic            start;
   logic            rs_sel;
   logic            poll_busy;
   logic            ready;
   logic            done;
   logic [7:0]      rd_data;
   logic            busy_flag;
   logic [AC_MSB:0] addr_count;
   logic            timeout;

   modport master (
      output start, rs_sel, poll_busy,
      input  ready, done, rd_data, busy_flag, addr_count, timeout
   );

   modport slave (
      input  start, rs_sel, poll_busy,
      output ready, done, rd_data, busy_flag, addr_count, timeout
   );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with a zero flag; times the LCD bus phases.
module lcd_phase_timer #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 8-bit read-cycle engine: single status/data reads, or busy-flag
// polling until BF=0 or the poll limit is reached.
module lcd_status_reader
   import lcd_pkg::*;
#(
   parameter int unsigned T_AS     = lcd_pkg::T_AS,
   parameter int unsigned T_EH     = lcd_pkg::T_EH,
   parameter int unsigned T_AH     = lcd_pkg::T_AH,
   parameter int unsigned T_GAP    = lcd_pkg::T_GAP,
   parameter int unsigned POLL_MAX = lcd_pkg::POLL_MAX
) (
   input  logic                      clk,
   input  logic                      rst,
   lcd_status_reader_if.slave        host,
   output logic                      LCD_RS,
   output logic                      LCD_RW,
   output logic                      LCD_EN,
   input  logic [7:0]                LCD_DATA_IN
);

   localparam logic [PCNT_W-1:0] POLL_LIM = PCNT_W'(POLL_MAX);

   rd_state_t          state;
   rd_state_t          state_nx;
   logic               tmr_load;
   logic               tmr_zero;
   logic [TMR_W-1:0]   tmr_val;
   logic               rs_q;
   logic               poll_q;
   logic [PCNT_W-1:0]  poll_cnt;
   logic [7:0]         rd_data_q;
   logic               bf_q;
   logic [AC_MSB:0]    ac_q;
   logic               timeout_q;
   logic               accept;
   logic               sample;
   logic               last_read;

   assign accept    = (state == S_IDLE) && host.start;
   assign sample    = (state == S_EN_HIGH) && tmr_zero;
   assign last_read = !poll_q || !bf_q || (poll_cnt == POLL_LIM);

   lcd_phase_timer #(.WIDTH(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (host.start) state_nx = S_SETUP;
         S_SETUP:   if (tmr_zero)   state_nx = S_EN_HIGH;
         S_EN_HIGH: if (tmr_zero)   state_nx = S_HOLD;
         S_HOLD:    if (tmr_zero)   state_nx = S_CHECK;
         S_CHECK:   state_nx = last_read ? S_DONE : S_GAP;
         S_GAP:     if (tmr_zero)   state_nx = S_SETUP;
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // The timer is reloaded on every state change with the length of the phase being entered.
   always_comb begin
      tmr_load = (state_nx != state);
      unique case (state_nx)
         S_SETUP:   tmr_val = phase_load(T_AS);
         S_EN_HIGH: tmr_val = phase_load(T_EH);
         S_HOLD:    tmr_val = phase_load(T_AH);
         S_GAP:     tmr_val = phase_load(T_GAP);
         default:   tmr_val = '0;
      endcase
   end

   always_comb begin
      host.ready = 1'b0;
      host.done  = 1'b0;
      LCD_RS     = RS_STATUS;
      LCD_RW     = RW_WRITE;
      LCD_EN     = 1'b0;
      unique case (state)
         S_IDLE: host.ready = 1'b1;
         S_SETUP, S_HOLD, S_CHECK, S_GAP: begin
            LCD_RS = rs_q;
            LCD_RW = RW_READ;
         end
         S_EN_HIGH: begin
            LCD_RS = rs_q;
            LCD_RW = RW_READ;
            LCD_EN = 1'b1;
         end
         S_DONE: host.done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rs_q      <= RS_STATUS;
         poll_q    <= 1'b0;
         poll_cnt  <= '0;
         rd_data_q <= '0;
         bf_q      <= 1'b0;
         ac_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (accept) begin
            rs_q      <= host.poll_busy ? RS_STATUS : host.rs_sel;
            poll_q    <= host.poll_busy;
            timeout_q <= 1'b0;
            poll_cnt  <= PCNT_W'(1);
         end
         // Bus has been stable for the whole EN-high phase, so one capture register is enough.
         if (sample) begin
            rd_data_q <= LCD_DATA_IN;
            if (rs_q == RS_STATUS) begin
               bf_q <= LCD_DATA_IN[BF_BIT];
               ac_q <= LCD_DATA_IN[AC_MSB:0];
            end
         end
         if ((state == S_CHECK) && poll_q && bf_q) begin
            if (poll_cnt == POLL_LIM) timeout_q <= 1'b1;
            else                      poll_cnt  <= poll_cnt + PCNT_W'(1);
         end
      end
   end

   assign host.rd_data    = rd_data_q;
   assign host.busy_flag  = bf_q;
   assign host.addr_count = ac_q;
   assign host.timeout    = timeout_q;

endmodule
